// File: rtl/code_transmitter.sv
// code_transmitter: sends a start pulse followed by four colour pulses taken
// from an 8-bit code (MSB element first). Each pulse pair is separated by a
// programmable number of all-zero gap cycles, and a done pulse closes the
// sequence. Requests that contain an invalid (00) element are rejected with
// a one-cycle Err flag. Every output is registered.
module code_transmitter #(
    parameter int GAP_W = 4
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic             Go,
    input  logic [7:0]       Code,
    input  logic [GAP_W-1:0] Gap,
    output logic             Start,
    output logic             Red,
    output logic             Green,
    output logic             Blue,
    output logic             Busy,
    output logic             Done,
    output logic             Err
);

    typedef enum logic [2:0] {
        S_Idle,
        S_Start,
        S_Gap,
        S_Color,
        S_Done
    } state_t;

    localparam logic [1:0] COL_RED   = 2'b01;
    localparam logic [1:0] COL_GREEN = 2'b10;
    localparam logic [1:0] COL_BLUE  = 2'b11;

    state_t           state, state_d;
    logic [1:0]       idx, idx_d;
    logic [GAP_W-1:0] cnt, cnt_d;
    logic [7:0]       code_q, code_d;
    logic [GAP_W-1:0] gap_q, gap_d;

    logic             start_d, red_d, green_d, blue_d;
    logic             busy_d, done_d, err_d;
    logic [1:0]       col_d;

    // Element i of a code word; element 0 sits in the top two bits.
    function automatic logic [1:0] elem(input logic [7:0] c, input logic [1:0] i);
        logic [1:0] e;
        case (i)
            2'd0:    e = c[7:6];
            2'd1:    e = c[5:4];
            2'd2:    e = c[3:2];
            default: e = c[1:0];
        endcase
        return e;
    endfunction

    // A code is transmittable only if none of its four elements is 00.
    function automatic logic code_ok(input logic [7:0] c);
        return (c[7:6] != 2'b00) && (c[5:4] != 2'b00) &&
               (c[3:2] != 2'b00) && (c[1:0] != 2'b00);
    endfunction

    // Next-state, sequencing counters and next-cycle output decode.
    always_comb begin
        state_d = state;
        idx_d   = idx;
        cnt_d   = cnt;
        code_d  = code_q;
        gap_d   = gap_q;
        err_d   = 1'b0;

        case (state)
            S_Idle: begin
                if (Go) begin
                    if (code_ok(Code)) begin
                        code_d  = Code;
                        gap_d   = Gap;
                        idx_d   = 2'd0;
                        state_d = S_Start;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            S_Start: begin
                if (gap_q != '0) begin
                    // Counter runs gap-1 down to 0, giving exactly gap cycles.
                    cnt_d   = gap_q - 1'b1;
                    state_d = S_Gap;
                end else begin
                    state_d = S_Color;
                end
            end
            S_Gap: begin
                if (cnt == '0) begin
                    state_d = S_Color;
                end else begin
                    cnt_d = cnt - 1'b1;
                end
            end
            S_Color: begin
                if (idx == 2'd3) begin
                    state_d = S_Done;
                end else begin
                    idx_d = idx + 2'd1;
                    if (gap_q != '0) begin
                        cnt_d   = gap_q - 1'b1;
                        state_d = S_Gap;
                    end else begin
                        state_d = S_Color;
                    end
                end
            end
            S_Done: begin
                state_d = S_Idle;
            end
            default: begin
                state_d = S_Idle;
            end
        endcase

        // Outputs are decoded from the state being entered so that they can
        // be registered and still line up with that state's cycle.
        col_d   = elem(code_d, idx_d);
        start_d = (state_d == S_Start);
        red_d   = (state_d == S_Color) && (col_d == COL_RED);
        green_d = (state_d == S_Color) && (col_d == COL_GREEN);
        blue_d  = (state_d == S_Color) && (col_d == COL_BLUE);
        busy_d  = (state_d != S_Idle);
        done_d  = (state_d == S_Done);
    end

    // Control state and registered outputs; reset aborts any sequence.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            state <= S_Idle;
            idx   <= 2'd0;
            cnt   <= '0;
            Start <= 1'b0;
            Red   <= 1'b0;
            Green <= 1'b0;
            Blue  <= 1'b0;
            Busy  <= 1'b0;
            Done  <= 1'b0;
            Err   <= 1'b0;
        end else begin
            state <= state_d;
            idx   <= idx_d;
            cnt   <= cnt_d;
            Start <= start_d;
            Red   <= red_d;
            Green <= green_d;
            Blue  <= blue_d;
            Busy  <= busy_d;
            Done  <= done_d;
            Err   <= err_d;
        end
    end

    // Latched code and gap; they only change when a request is accepted.
    always_ff @(posedge Clk) begin
        code_q <= code_d;
        gap_q  <= gap_d;
    end

endmodule

// File: tb/tb_code_transmitter.sv
// Testbench for code_transmitter: directed scenarios followed by random
// traffic, compared each cycle against a queue-based timeline model.
module tb_code_transmitter;

    localparam int GAP_W = 4;

    logic             Clk;
    logic             Rst;
    logic             Go;
    logic [7:0]       Code;
    logic [GAP_W-1:0] Gap;
    logic             Start, Red, Green, Blue, Busy, Done, Err;

    // Output word layout: {Start, Red, Green, Blue, Busy, Done, Err}
    localparam logic [6:0] W_IDLE  = 7'b0000000;
    localparam logic [6:0] W_ERR   = 7'b0000001;
    localparam logic [6:0] W_START = 7'b1000100;
    localparam logic [6:0] W_GAP   = 7'b0000100;
    localparam logic [6:0] W_RED   = 7'b0100100;
    localparam logic [6:0] W_GREEN = 7'b0010100;
    localparam logic [6:0] W_BLUE  = 7'b0001100;
    localparam logic [6:0] W_DONE  = 7'b0000110;

    int errors = 0;
    int checks = 0;

    logic [6:0] q[$];
    logic [6:0] exp_w;
    logic [6:0] obs_w;

    code_transmitter #(.GAP_W(GAP_W)) dut (
        .Clk   (Clk),
        .Rst   (Rst),
        .Go    (Go),
        .Code  (Code),
        .Gap   (Gap),
        .Start (Start),
        .Red   (Red),
        .Green (Green),
        .Blue  (Blue),
        .Busy  (Busy),
        .Done  (Done),
        .Err   (Err)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    function automatic logic [6:0] colour_word(input logic [7:0] c, input int k);
        int e;
        e = (int'(c) >> (6 - 2 * k)) & 3;
        case (e)
            1:       return W_RED;
            2:       return W_GREEN;
            3:       return W_BLUE;
            default: return W_IDLE;
        endcase
    endfunction

    function automatic bit valid_code(input logic [7:0] c);
        for (int k = 0; k < 4; k++)
            if (((int'(c) >> (6 - 2 * k)) & 3) == 0) return 1'b0;
        return 1'b1;
    endfunction

    // Whole expected timeline of one accepted request, one word per cycle
    // starting with the cycle after the accepting edge. The trailing idle
    // word is the mandatory idle cycle before the next request can land.
    task automatic load_sequence(input logic [7:0] c, input int g);
        q.push_back(W_START);
        for (int k = 0; k < 4; k++) begin
            for (int i = 0; i < g; i++) q.push_back(W_GAP);
            q.push_back(colour_word(c, k));
        end
        q.push_back(W_DONE);
        q.push_back(W_IDLE);
    endtask

    // Apply inputs for one edge, advance the model, then compare.
    task automatic step(input logic go, input logic [7:0] code,
                        input logic [GAP_W-1:0] gap, input logic rst,
                        input string tag);
        Go   = go;
        Code = code;
        Gap  = gap;
        Rst  = rst;
        @(posedge Clk);
        if (rst) begin
            q.delete();
            exp_w = W_IDLE;
        end else begin
            exp_w = W_IDLE;
            if (q.size() == 0 && go) begin
                if (valid_code(code)) load_sequence(code, int'(gap));
                else exp_w = W_ERR;
            end
            if (q.size() > 0) exp_w = q.pop_front();
        end
        #1;
        obs_w = {Start, Red, Green, Blue, Busy, Done, Err};
        checks++;
        assert (obs_w === exp_w) else begin
            errors++;
            $error("FAIL %s t=%0t observed=%b expected=%b", tag, $time, obs_w, exp_w);
        end
    endtask

    task automatic idle(input int n, input string tag);
        for (int i = 0; i < n; i++) step(1'b0, 8'h00, '0, 1'b0, tag);
    endtask

    initial begin
        logic [7:0]       rc;
        logic [GAP_W-1:0] rg;
        logic             rgo, rrst;

        Rst = 1'b1; Go = 1'b0; Code = 8'h00; Gap = '0;

        // Reset state, with a Go that must be ignored under reset
        step(1'b0, 8'h79, 4'd0, 1'b1, "reset0");
        step(1'b1, 8'h79, 4'd0, 1'b1, "reset_go");
        idle(2, "post_reset");

        // 0x79, gap 0: Start, Red, Blue, Green, Red, Done
        step(1'b1, 8'h79, 4'd0, 1'b0, "g0_go");
        idle(8, "g0_seq");

        // 0x79, gap 3
        step(1'b1, 8'h79, 4'd3, 1'b0, "g3_go");
        idle(20, "g3_seq");

        // Invalid element -> Err only, then a held invalid Go repeats Err
        step(1'b1, 8'h49, 4'd2, 1'b0, "inv_go");
        step(1'b1, 8'h49, 4'd2, 1'b0, "inv_hold");
        idle(3, "inv_after");
        step(1'b1, 8'h7C, 4'd0, 1'b0, "inv_last");
        idle(2, "inv_after2");

        // Inputs changed mid-sequence must not affect it
        step(1'b1, 8'h79, 4'd2, 1'b0, "chg_go");
        for (int i = 0; i < 10; i++) step(1'b1, 8'hFF, 4'd5, 1'b0, "chg_seq");
        idle(8, "chg_tail");

        // Reset during the gap before element 2, then immediate restart
        step(1'b1, 8'h79, 4'd3, 1'b0, "rst_go");
        idle(10, "rst_seq");
        step(1'b0, 8'h00, 4'd0, 1'b1, "rst_mid");
        step(1'b1, 8'hE4 | 8'h55, 4'd1, 1'b1, "rst_go_ign");
        step(1'b1, 8'hB6, 4'd1, 1'b0, "rst_restart");
        idle(12, "rst_restart_seq");

        // Back-to-back requests: Go held high throughout
        for (int i = 0; i < 20; i++) step(1'b1, 8'hDB, 4'd1, 1'b0, "b2b");
        idle(12, "b2b_tail");

        // Maximum gap
        step(1'b1, 8'h9E, 4'd15, 1'b0, "gmax_go");
        idle(70, "gmax_seq");

        // Random traffic
        for (int i = 0; i < 900; i++) begin
            rc = 8'($urandom);
            if ($urandom_range(0, 1) == 0) rc = rc | 8'h55;
            rg   = GAP_W'($urandom);
            rgo  = ($urandom_range(0, 2) == 0);
            rrst = ($urandom_range(0, 120) == 0);
            step(rgo, rc, rg, rrst, "rand");
        end
        idle(70, "rand_drain");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
